// File: rtl/charge_arbiter.sv
// Two-bay charger arbiter: round-robin grant, unit metering with saturation,
// and a one-cycle billing pulse at the end of every session.
module charge_arbiter #(
  parameter int unsigned MAX_UNITS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] fast,
  input  logic [1:0] cancel,
  input  logic       unit_tick,
  output logic [1:0] grant,
  output logic       busy,
  output logic [3:0] units,
  output logic [4:0] fee,
  output logic       done,
  output logic       done_bay,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StCharge = 2'b01,
    StBill   = 2'b10
  } state_e;

  localparam logic [3:0] MaxUnits = 4'(MAX_UNITS);

  state_e     state_q, state_d;
  logic       bay_q, bay_d;     // granted bay index
  logic       rr_q, rr_d;       // bay preferred when both request
  logic       mode_q, mode_d;   // 1 = fast tariff for the current session
  logic [3:0] units_q, units_d;
  logic [4:0] fee_q, fee_d;
  logic [3:0] units_inc;
  logic       session_end;

  // Fast tariff charges half a unit extra per unit, rounded down.
  function automatic logic [4:0] bill_fee(input logic m, input logic [3:0] u);
    return m ? (5'(u) + 5'(u >> 1)) : 5'(u);
  endfunction

  // Next-state: arbitration in idle, metering in charge, single-cycle bill.
  always_comb begin
    state_d     = state_q;
    bay_d       = bay_q;
    rr_d        = rr_q;
    mode_d      = mode_q;
    units_d     = units_q;
    fee_d       = fee_q;
    units_inc   = (units_q == MaxUnits) ? units_q : units_q + 4'd1;
    // Only the granted bay can end its own session.
    session_end = cancel[bay_q] | ~req[bay_q];
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          bay_d   = (&req) ? rr_q : req[1];
          rr_d    = ~bay_d;
          mode_d  = fast[bay_d];
          units_d = '0;
          state_d = StCharge;
        end
      end
      StCharge: begin
        // Cancel / request drop beats a coincident tick.
        if (session_end) begin
          fee_d   = bill_fee(mode_q, units_q);
          state_d = StBill;
        end else if (unit_tick) begin
          units_d = units_inc;
          if (units_inc == MaxUnits) begin
            fee_d   = bill_fee(mode_q, units_inc);
            state_d = StBill;
          end
        end
      end
      StBill: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, cleared asynchronously so a reset aborts any session.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bay_q   <= 1'b0;
      rr_q    <= 1'b0;
      mode_q  <= 1'b0;
      units_q <= '0;
      fee_q   <= '0;
    end else begin
      state_q <= state_d;
      bay_q   <= bay_d;
      rr_q    <= rr_d;
      mode_q  <= mode_d;
      units_q <= units_d;
      fee_q   <= fee_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q == StCharge);
  assign done     = (state_q == StBill);
  assign grant    = busy ? (bay_q ? 2'b10 : 2'b01) : 2'b00;
  assign done_bay = done & bay_q;
  assign units    = units_q;
  assign fee      = fee_q;

endmodule

// File: tb/tb_charge_arbiter.sv
// Bench for charge_arbiter: a session-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_charge_arbiter;

  localparam int Max = 9;

  logic       clk;
  logic       reset;
  logic [1:0] req, fast, cancel;
  logic       unit_tick;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] units;
  logic [4:0] fee;
  logic       done;
  logic       done_bay;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1 charging, 2 billing.
  int m_phase = 0;
  int m_bay   = 0;
  int m_rr    = 0;
  int m_mode  = 0;
  int m_units = 0;
  int m_fee   = 0;

  charge_arbiter #(.MAX_UNITS(Max)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .fast      (fast),
    .cancel    (cancel),
    .unit_tick (unit_tick),
    .grant     (grant),
    .busy      (busy),
    .units     (units),
    .fee       (fee),
    .done      (done),
    .done_bay  (done_bay),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int tariff(input int mode, input int u);
    return (mode != 0) ? u + u / 2 : u;
  endfunction

  // Advance the model by one clock edge from the sampled inputs.
  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_bay = 0; m_rr = 0; m_mode = 0; m_units = 0; m_fee = 0;
    end else if (m_phase == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_bay = m_rr;
        else              m_bay = (req == 2'b10) ? 1 : 0;
        m_rr    = 1 - m_bay;
        m_mode  = fast[m_bay];
        m_units = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (cancel[m_bay] || !req[m_bay]) begin
        m_fee   = tariff(m_mode, m_units);
        m_phase = 2;
      end else if (unit_tick) begin
        m_units++;
        if (m_units >= Max) begin
          m_units = Max;
          m_fee   = tariff(m_mode, m_units);
          m_phase = 2;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare();
    chk("state", state, m_phase);
    chk("grant", grant, (m_phase == 1) ? (1 << m_bay) : 0);
    chk("busy",  busy,  (m_phase == 1) ? 1 : 0);
    chk("done",  done,  (m_phase == 2) ? 1 : 0);
    chk("units", units, m_units);
    if (m_phase == 2 || reset) begin
      chk("fee",      fee,      m_fee);
      chk("done_bay", done_bay, (m_phase == 2) ? m_bay : 0);
    end
  endtask

  // Per-cycle compare process.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      compare();
    end
  end

  // Apply inputs at the falling edge, return just after the next rising edge.
  task automatic step(input logic [1:0] r, input logic [1:0] f,
                      input logic [1:0] c, input logic t);
    @(negedge clk);
    req = r; fast = f; cancel = c; unit_tick = t;
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 2'b00; fast = 2'b00; cancel = 2'b00; unit_tick = 1'b0;
    @(posedge clk);
    #3;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 2'b00; fast = 2'b00; cancel = 2'b00; unit_tick = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_state", state, 0);
    chk("rst_units", units, 0);
    chk("rst_fee",   fee,   0);
    @(negedge clk);
    reset = 1'b0;

    // Single bay, slow, three units then cancel.
    step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("t1_grant", grant, 1);
    repeat (3) step(2'b01, 2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 2'b01, 1'b0);
    chk("t1_done",  done, 1);
    chk("t1_fee",   fee, 3);
    chk("t1_units", units, 3);
    chk("t1_bay",   done_bay, 0);
    step(2'b00, 2'b00, 2'b00, 1'b0);

    // Both bays requesting from reset: grants alternate 0,1,0,1.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      int g;
      g = s % 2;
      step(2'b11, 2'b00, 2'b00, 1'b0);
      chk("t2_grant", grant, (g == 0) ? 1 : 2);
      step(2'b11, 2'b00, 2'((1 << g)), 1'b0);
      chk("t2_bay", done_bay, g);
      step(2'b11, 2'b00, 2'b00, 1'b0);
      chk("t2_idle", state, 0);
    end
    step(2'b00, 2'b00, 2'b00, 1'b0);

    // Bay 1 fast, runs to the unit limit.
    step(2'b10, 2'b10, 2'b00, 1'b0);
    chk("t3_grant", grant, 2);
    repeat (8) step(2'b10, 2'b10, 2'b00, 1'b1);
    chk("t3_state8", state, 1);
    step(2'b10, 2'b10, 2'b00, 1'b1);
    chk("t3_state9", state, 2);
    chk("t3_units",  units, 9);
    chk("t3_fee",    fee, 13);
    step(2'b10, 2'b10, 2'b00, 1'b1);
    chk("t3_units10", units, 9);
    step(2'b00, 2'b00, 2'b00, 1'b1);
    chk("t3_idle_tick", units, 9);

    // Cancel and tick together: cancel wins.
    step(2'b01, 2'b00, 2'b00, 1'b0);
    repeat (2) step(2'b01, 2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 2'b01, 1'b1);
    chk("t4_units", units, 2);
    chk("t4_fee",   fee, 2);
    step(2'b00, 2'b00, 2'b00, 1'b0);

    // Bay 1 granted; bay 0 cancel ignored; bay 0 request stays pending.
    step(2'b11, 2'b00, 2'b00, 1'b0);
    chk("t5_grant", grant, 2);
    step(2'b11, 2'b00, 2'b01, 1'b0);
    chk("t5_ignore", state, 1);
    step(2'b11, 2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("t5_done", done, 1);
    chk("t5_bay",  done_bay, 1);
    chk("t5_fee",  fee, 1);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    chk("t5_pending", grant, 1);
    step(2'b01, 2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);

    // Asynchronous reset mid-session.
    step(2'b01, 2'b01, 2'b00, 1'b0);
    repeat (4) step(2'b01, 2'b01, 2'b00, 1'b1);
    chk("t6_units4", units, 4);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy",  busy, 0);
    chk("t6_units", units, 0);
    chk("t6_state", state, 0);
    chk("t6_done",  done, 0);
    @(posedge clk);
    #3;
    @(negedge clk);
    reset = 1'b0;
    req = 2'b00; unit_tick = 1'b0;
    step(2'b00, 2'b00, 2'b00, 1'b0);
    chk("t6_nodone", done, 0);
    chk("t6_fee",    fee, 0);
    step(2'b00, 2'b00, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/charge_arbiter.md
CHARGE_ARBITER -- requirements
Module: charge_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_UNITS, default 9, giving the session unit limit (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 2 bits: per-bay charge request, a level held by the bay for the whole session.
REQ-005 The block SHALL have port fast, input, 2 bits: per-bay fast-mode select, sampled at grant.
REQ-006 The block SHALL have port cancel, input, 2 bits: per-bay cancel pulse.
REQ-007 The block SHALL have port unit_tick, input, 1 bit: one-cycle pulse, one charge unit delivered.
REQ-008 The block SHALL have port grant, output, 2 bits: one-hot charger ownership, 00 when free.
REQ-009 The block SHALL have port busy, output, 1 bit: high in CHARGE.
REQ-010 The block SHALL have port units, output, 4 bits: units counted in the current or last session.
REQ-011 The block SHALL have port fee, output, 5 bits: bill of the last session.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse while fee is valid.
REQ-013 The block SHALL have port done_bay, output, 1 bit: the bay index the done pulse belongs to.
REQ-014 The block SHALL have port state, output, 2 bits: FSM state code, IDLE=00, CHARGE=01, BILL=10.

Function
REQ-015 FSM transitions SHALL be: IDLE->CHARGE, CHARGE->BILL, and BILL->IDLE, the last unconditionally after 1 cycle.
REQ-016 In IDLE with any req bit high, the FSM SHALL move to CHARGE on the next edge, with grant one-hot registered on the same edge (1-cycle latency).
REQ-017 When both req bits are high in IDLE, the winner SHALL be the bay selected by the round-robin pointer rr (reset 0).
REQ-018 When only one req bit is high in IDLE, that bay SHALL win regardless of rr.
REQ-019 On each grant, rr SHALL be set to the non-granted bay.
REQ-020 On entry to CHARGE, units SHALL clear to 0 and the granted bay's fast bit SHALL be latched into an internal mode register.
REQ-021 In CHARGE, each unit_tick SHALL increment units by 1.
REQ-022 units SHALL saturate at MAX_UNITS and never wrap.
REQ-023 Session end SHALL occur when units reaches MAX_UNITS: the tick that makes units==MAX_UNITS moves the FSM to BILL on the same edge.
REQ-024 Session end SHALL also occur on cancel[g] high or req[g] low for granted bay g: the FSM moves to BILL on the next edge.
REQ-025 When cancel[g] and unit_tick occur in the same cycle, cancel SHALL win and the tick SHALL be ignored.
REQ-026 cancel and req of the non-granted bay SHALL be ignored during CHARGE.
REQ-027 The non-granted bay's req SHALL be held pending and not lost.
REQ-028 In slow mode, the fee computed on entry to BILL SHALL be fee = units.
REQ-029 In fast mode, the fee computed on entry to BILL SHALL be fee = units + (units >> 1), 5-bit unsigned (max 22 with MAX_UNITS=15; no overflow).
REQ-030 In BILL, grant SHALL be 00, busy 0, done 1 and done_bay = g for exactly one cycle.
REQ-031 fee and units SHALL hold until the next grant.
REQ-032 A bay still requesting after BILL SHALL be treated as a new request in IDLE, subject to rr.
REQ-033 unit_tick outside CHARGE SHALL be ignored.
REQ-034 grant SHALL never have both bits set.

Reset
REQ-035 While reset is high, state SHALL be IDLE; grant=00, busy=0, units=0, fee=0, done=0, done_bay=0, rr=0, and the mode register SHALL be 0.
REQ-036 Reset asserted mid-CHARGE or mid-BILL SHALL abort the session immediately, with no done pulse and no fee update.
REQ-037 After reset deasserts, the first edge SHALL evaluate req from IDLE.

Verification
REQ-038 req=01, fast=00, 3 unit_ticks, then cancel=01 -> grant=01 one cycle after req; units=3; done pulse with fee=3, done_bay=0.
REQ-039 req=11 from reset -> bay 0 granted first; after its session, bay 1 granted on the cycle after BILL; rr alternates over 4 sessions.
REQ-040 req=10, fast=10, 9 unit_ticks (MAX_UNITS=9) -> BILL entered on the 9th tick edge; units=9; fee=13; 10th tick ignored.
REQ-041 Granted bay 0: unit_tick and cancel=01 in the same cycle -> units unchanged; fee equals the prior count.
REQ-042 Granted bay 1: cancel=01 then req[1] drops -> bay 0 cancel ignored; session ends on the req drop with done_bay=1.
REQ-043 Reset pulse after 4 ticks in CHARGE -> all outputs 0 asynchronously; no done pulse.
